// File: rtl/camera_capture.sv
// Parallel camera bus capture: synchronises pclk/vsync/href/data into the system clock domain
// and assembles RGB565 byte pairs into pixels with x/y coordinates and frame pulses.
module camera_capture #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_done,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {StWaitCfg, StWaitVsync, StCapture} state_e;

  // {pclk, vsync, href, data} shifted together so all fields see the same delay
  logic [SYNC_STAGES-1:0][10:0] cam_sync_q;
  logic                         pclk_s, vsync_s, href_s;
  logic [7:0]                   data_s;
  logic                         pclk_prev_q, vsync_prev_q, href_prev_q;
  logic                         pclk_rise, vsync_rise, vsync_fall, href_fall;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_count_q, frame_count_d;

  assign {pclk_s, vsync_s, href_s, data_s} = cam_sync_q[SYNC_STAGES-1];

  assign pclk_rise  = pclk_s & ~pclk_prev_q;
  assign vsync_rise = vsync_s & ~vsync_prev_q;
  assign vsync_fall = ~vsync_s & vsync_prev_q;
  assign href_fall  = ~href_s & href_prev_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    x_d           = x_q;
    y_d           = y_q;
    pix_data_d    = pix_data_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (!cfg_done) begin
      state_d = StWaitCfg;
    end else begin
      unique case (state_q)
        StWaitCfg: state_d = StWaitVsync;
        StWaitVsync: begin
          if (vsync_fall) begin
            frame_start_d = 1'b1;
            x_d           = '0;
            y_d           = '0;
            phase_d       = 1'b0;
            state_d       = StCapture;
          end
        end
        StCapture: begin
          if (pclk_rise && href_s) begin
            if (!phase_q) begin
              hi_d    = data_s;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (({22'd0, x_q} < H_ACTIVE) && ({22'd0, y_q} < V_ACTIVE)) begin
                pix_valid_d = 1'b1;
                pix_data_d  = {hi_q, data_s};
                pix_x_d     = x_q;
                pix_y_d     = y_q;
              end
              x_d = (x_q == 10'h3FF) ? x_q : x_q + 10'd1;
            end
          end
          // Empty lines do not advance y; an unpaired trailing byte is dropped
          if (href_fall) begin
            if (x_q != '0) y_d = (y_q == 10'h3FF) ? y_q : y_q + 10'd1;
            x_d     = '0;
            phase_d = 1'b0;
          end
          if (vsync_rise) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
            state_d       = StWaitVsync;
          end
        end
        default: state_d = StWaitCfg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cam_sync_q    <= '0;
      pclk_prev_q   <= 1'b0;
      vsync_prev_q  <= 1'b0;
      href_prev_q   <= 1'b0;
      state_q       <= StWaitCfg;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      cam_sync_q    <= {cam_sync_q[SYNC_STAGES-2:0], {cam_pclk, cam_vsync, cam_href, cam_data}};
      pclk_prev_q   <= pclk_s;
      vsync_prev_q  <= vsync_s;
      href_prev_q   <= href_s;
      state_q       <= state_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_data_q    <= pix_data_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench for camera_capture: a camera model pushes expected pixels as it drives bytes;
// a negedge monitor pops and compares on each pix_valid strobe.
module tb_camera_capture;

  localparam int unsigned HA = 4;
  localparam int unsigned VA = 3;
  localparam int unsigned SS = 2;

  logic        clk, rst, cfg_done, cam_pclk, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic [15:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic        pix_valid, frame_start, frame_done;
  logic [7:0]  frame_count;

  camera_capture #(
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .SYNC_STAGES(SS)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_done   (cfg_done),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected pixels: {data[15:0], x[9:0], y[9:0]}
  logic [35:0] exp_q[$];
  logic [35:0] mon_e, first_e;
  logic [9:0]  last_x, last_y;
  int          pix_cnt = 0, fs_cnt = 0, fd_cnt = 0;

  // Camera model state
  bit          m_active = 0;
  bit          m_phase  = 0;
  int          mx = 0, my = 0;
  logic [7:0]  m_hi = '0;
  int          exp_fs = 0, exp_fd = 0;
  logic [7:0]  exp_fc = '0;
  logic [7:0]  next_b = 8'h12;

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) begin
        pix_cnt++;
        if (exp_q.size() == 0) begin
          check("pix_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pix_data", {16'd0, pix_data}, {16'd0, mon_e[35:20]});
          check("pix_x", {22'd0, pix_x}, {22'd0, mon_e[19:10]});
          check("pix_y", {22'd0, pix_y}, {22'd0, mon_e[9:0]});
          if (pix_cnt == 1) first_e = {pix_data, pix_x, pix_y};
          last_x = pix_x;
          last_y = pix_y;
        end
      end
      if (frame_start) fs_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    cam_data = d;
    cam_pclk = 1'b0;
    wait_clks(4);
    cam_pclk = 1'b1;
    if (m_active) begin
      if (!m_phase) begin
        m_hi    = d;
        m_phase = 1;
      end else begin
        m_phase = 0;
        if (mx < int'(HA) && my < int'(VA)) exp_q.push_back({m_hi, d, 10'(mx), 10'(my)});
        if (mx < 1023) mx++;
      end
    end
    wait_clks(4);
  endtask

  task automatic model_frame_end();
    if (m_active) begin
      exp_fd++;
      exp_fc  = exp_fc + 8'd1;
      m_active = 0;
    end
  endtask

  task automatic send_line(input int nbytes, input bit end_frame = 0);
    cam_href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(next_b);
      next_b = next_b + 8'h22;
    end
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    if (end_frame) cam_vsync = 1'b1;
    if (m_active) begin
      if (mx > 0 && my < 1023) my++;
      mx      = 0;
      m_phase = 0;
    end
    if (end_frame) model_frame_end();
    wait_clks(8);
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b1;
    wait_clks(8);
    cam_vsync = 1'b0;
    if (cfg_done) begin
      m_active = 1;
      mx       = 0;
      my       = 0;
      m_phase  = 0;
      exp_fs++;
    end
    wait_clks(8);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    model_frame_end();
    wait_clks(8);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cfg_done  = 1'b0;
    cam_pclk  = 1'b0;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = '0;
    wait_clks(4);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_frame_count", {24'd0, frame_count}, 32'd0);
    check("rst_pix_data", {16'd0, pix_data}, 32'd0);
    rst = 1'b0;
    wait_clks(2);

    // cfg_done low: nothing should come out
    frame_begin();
    repeat (3) send_line(8);
    frame_end();
    check("nocfg_pix", pix_cnt, 0);
    check("nocfg_fs", fs_cnt, 0);
    check("nocfg_fd", fd_cnt, 0);

    // 4x3 frame
    cfg_done = 1'b1;
    wait_clks(4);
    next_b = 8'h12;
    frame_begin();
    repeat (3) send_line(8);
    frame_end();
    check("f1_pix_cnt", pix_cnt, 12);
    check("f1_first", {28'd0, first_e[35:32]}, 32'd1);
    check("f1_first_pix", {12'd0, first_e[35:16]}, {12'd0, 16'h1234, 4'd0});
    check("f1_last_x", {22'd0, last_x}, 32'd3);
    check("f1_last_y", {22'd0, last_y}, 32'd2);
    check("f1_fs", fs_cnt, exp_fs);
    check("f1_fd", fd_cnt, exp_fd);
    check("f1_count", {24'd0, frame_count}, 32'd1);

    // Long line (6 pixels) clipped at H_ACTIVE, extra line clipped at V_ACTIVE
    frame_begin();
    send_line(12);
    repeat (3) send_line(8);
    frame_end();
    check("clip_pix_cnt", pix_cnt, 24);
    check("clip_count", {24'd0, frame_count}, {24'd0, exp_fc});

    // Odd-length line, then href fall coinciding with vsync rise
    frame_begin();
    send_line(9);
    send_line(8, 1);
    check("odd_pix_cnt", pix_cnt, 32);
    check("odd_fd", fd_cnt, exp_fd);
    check("odd_count", {24'd0, frame_count}, {24'd0, exp_fc});

    // cfg_done dropped mid-frame: frame abandoned, restart at next vsync fall
    frame_begin();
    send_line(8);
    cfg_done = 1'b0;
    m_active = 0;
    wait_clks(4);
    cfg_done = 1'b1;
    wait_clks(4);
    send_line(8);
    frame_end();
    check("cfgdrop_fd", fd_cnt, exp_fd);
    check("cfgdrop_count", {24'd0, frame_count}, {24'd0, exp_fc});
    frame_begin();
    send_line(8);
    frame_end();
    check("cfgdrop_fs", fs_cnt, exp_fs);
    check("cfgdrop_last_y", {22'd0, last_y}, 32'd0);
    check("cfgdrop_count2", {24'd0, frame_count}, {24'd0, exp_fc});

    // Reset mid-line
    frame_begin();
    cam_href = 1'b1;
    repeat (3) begin
      send_byte(next_b);
      next_b = next_b + 8'h22;
    end
    @(negedge clk);
    rst      = 1'b1;
    m_active = 0;
    exp_fc   = '0;
    @(negedge clk);
    check("mrst_pix_data", {16'd0, pix_data}, 32'd0);
    check("mrst_pix_x", {22'd0, pix_x}, 32'd0);
    check("mrst_pix_y", {22'd0, pix_y}, 32'd0);
    check("mrst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("mrst_fs_fd", {30'd0, frame_start, frame_done}, 32'd0);
    check("mrst_count", {24'd0, frame_count}, 32'd0);
    rst = 1'b0;
    send_byte(next_b);
    send_line(2);
    frame_end();
    check("mrst_no_fd", fd_cnt, exp_fd);

    // 256 frames: frame_count wraps
    for (int f = 0; f < 256; f++) begin
      frame_begin();
      send_line(2);
      frame_end();
      if (f == 254) check("wrap_255", {24'd0, frame_count}, 32'd255);
    end
    check("wrap_0", {24'd0, frame_count}, 32'd0);
    check("wrap_model", {24'd0, frame_count}, {24'd0, exp_fc});
    check("final_fs", fs_cnt, exp_fs);
    check("final_fd", fd_cnt, exp_fd);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
